// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: command codes, FSM state encodings,
// counter width default and the PC width used across the core.
package pipe_ctrl_pkg;

  localparam int PC_SIZE       = 32;
  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_STEP  = 2'b01,
    CMD_HALT  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the
// instruction in ID. Purely combinational, zero latency, no flow control.
module hazard_detect (
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       load_use
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use = mem_read & (ex_rt != 5'd0) & ((ex_rt == rs) | (ex_rt == rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Debug-controlled pipeline run/step/halt FSM, latch controls and cycle counter.
// Optional stall counter under PIPE_CTRL_STALL_CNT_EN; commands stall only in STEP.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_code,
  output logic             cmd_ready,
  input  logic             halt_instr,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             branch_taken,
  input  logic             jump_sel,
  output logic             enable,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] cycle_count,
`ifdef PIPE_CTRL_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_count,
`endif
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t cur, nxt;
  logic   accept, clr, load_use, flush, stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur <= ST_IDLE;
    else       cur <= nxt;
  end

  assign cmd_ready = (cur != ST_STEP);
  assign accept    = cmd_valid & cmd_ready;

  // halt_instr outranks any debug command while the pipe is advancing
  always_comb begin
    nxt = cur;
    clr = 1'b0;
    case (cur)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_code == CMD_RUN)        nxt = ST_RUN;
          else if (cmd_code == CMD_STEP)  nxt = ST_STEP;
          else if (cmd_code == CMD_CLEAR) clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_instr)                           nxt = ST_DONE;
        else if (accept && cmd_code == CMD_HALT)  nxt = ST_IDLE;
      end
      ST_STEP: nxt = halt_instr ? ST_DONE : ST_IDLE;
      ST_DONE: begin
        if (accept && cmd_code == CMD_CLEAR) begin
          nxt = ST_IDLE;
          clr = 1'b1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  assign state  = cur;
  assign enable = (cur == ST_RUN) | (cur == ST_STEP);

  hazard_detect u_hazard (
    .mem_read (id_ex_mem_read),
    .ex_rt    (id_ex_rt),
    .rs       (if_id_rs),
    .rt       (if_id_rt),
    .load_use (load_use)
  );

  // a taken branch squashes the dependent instruction, so no stall is needed
  assign flush        = enable & (branch_taken | jump_sel);
  assign stall        = enable & load_use & ~flush;
  assign if_id_flush  = flush;
  assign pc_write     = enable & ~stall;
  assign if_id_write  = ~stall;
  assign id_ex_bubble = stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  cycle_count <= '0;
    else if (clr)                               cycle_count <= '0;
    else if (enable && cycle_count != CNT_MAX)  cycle_count <= cycle_count + CNT_ONE;
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 stall_count <= '0;
    else if (clr)                              stall_count <= '0;
    else if (stall && stall_count != CNT_MAX)  stall_count <= stall_count + CNT_ONE;
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenario tasks plus a randomized run against a
// transition-table reference model; a second 4-bit-counter instance checks saturation.
module tb_pipe_ctrl;

  localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_DONE = 3;
  localparam logic [1:0] C_RUN = 2'b00, C_STEP = 2'b01, C_HALT = 2'b10, C_CLEAR = 2'b11;
  localparam longint MAX32 = 64'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset, cmd_valid, halt_instr, id_ex_mem_read, branch_taken, jump_sel;
  logic [1:0]  cmd_code;
  logic [4:0]  id_ex_rt, if_id_rs, if_id_rt;
  logic        cmd_ready, enable, pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [31:0] cycle_count;
  logic [1:0]  state;

  logic        reset_s, cmd_valid_s;
  logic [1:0]  cmd_code_s;
  logic        cmd_ready_s, enable_s, pc_write_s, if_id_write_s, if_id_flush_s, id_ex_bubble_s;
  logic [3:0]  cycle_count_s;
  logic [1:0]  state_s;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_count;
  logic [3:0]  stall_count_s;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready), .halt_instr(halt_instr), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt(id_ex_rt), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .branch_taken(branch_taken), .jump_sel(jump_sel), .enable(enable),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .cycle_count(cycle_count),
`ifdef PIPE_CTRL_STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .state(state)
  );

  pipe_ctrl #(.CNT_W(4)) dut_s (
    .clock(clock), .reset(reset_s), .cmd_valid(cmd_valid_s), .cmd_code(cmd_code_s),
    .cmd_ready(cmd_ready_s), .halt_instr(halt_instr), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt(id_ex_rt), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .branch_taken(branch_taken), .jump_sel(jump_sel), .enable(enable_s),
    .pc_write(pc_write_s), .if_id_write(if_id_write_s), .if_id_flush(if_id_flush_s),
    .id_ex_bubble(id_ex_bubble_s), .cycle_count(cycle_count_s),
`ifdef PIPE_CTRL_STALL_CNT_EN
    .stall_count(stall_count_s),
`endif
    .state(state_s)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    cmd_valid = 1'b0; cmd_code = 2'b00; halt_instr = 1'b0; id_ex_mem_read = 1'b0;
    id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0; branch_taken = 1'b0; jump_sel = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd_code  = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] got;
    @(posedge clock); #1;
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5; branch_taken = 1'b1;
    reset = 1'b1;
    #2;
    got = {state, enable, pc_write, if_id_flush, id_ex_bubble, cmd_ready, if_id_write};
    n_cmp++;
    if (got !== 8'b00_0000_11) begin
      n_bad++; $display("FAIL reset_outputs: got %b expected %b", got, 8'b00000011);
    end
    n_cmp++;
    if (cycle_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_count: got %0d expected 0", cycle_count);
    end
    clear_inputs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_run_count;
    send_cmd(C_RUN);
    n_cmp++;
    if ({state, enable, cmd_ready, cycle_count} !== {2'b01, 1'b1, 1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL run_enable: got state=%b en=%b rdy=%b cnt=%0d expected state=01 en=1 rdy=1 cnt=0",
               state, enable, cmd_ready, cycle_count);
    end
    repeat (10) tick();
    n_cmp++;
    if (cycle_count !== 32'd10) begin
      n_bad++; $display("FAIL run_count10: got %0d expected 10", cycle_count);
    end
    send_cmd(C_HALT);
    n_cmp++;
    if ({state, enable, cycle_count} !== {2'b00, 1'b0, 32'd11}) begin
      n_bad++;
      $display("FAIL halt_cmd: got state=%b en=%b cnt=%0d expected state=00 en=0 cnt=11",
               state, enable, cycle_count);
    end
  endtask

  task automatic test_step;
    int pulses = 0;
    send_cmd(C_CLEAR);
    n_cmp++;
    if ({state, cycle_count} !== {2'b00, 32'd0}) begin
      n_bad++; $display("FAIL idle_clear: got state=%b cnt=%0d expected 00/0", state, cycle_count);
    end
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'b1; cmd_code = C_STEP;
      tick();
      cmd_valid = 1'b0;
      n_cmp++;
      if ({enable, cmd_ready, state} !== 4'b1010) begin
        n_bad++; $display("FAIL step_pulse%0d: got en/rdy/state=%b expected 1010", k, {enable, cmd_ready, state});
      end
      for (int j = 0; j < 3; j++) begin
        tick();
        if (enable) pulses++;
      end
      n_cmp++;
      if ({enable, cmd_ready, state} !== 4'b0100) begin
        n_bad++; $display("FAIL step_after%0d: got en/rdy/state=%b expected 0100", k, {enable, cmd_ready, state});
      end
    end
    n_cmp++;
    if (pulses !== 0 || cycle_count !== 32'd3) begin
      n_bad++; $display("FAIL step_total: got extra_pulses=%0d cnt=%0d expected 0/3", pulses, cycle_count);
    end
  endtask

  task automatic test_hazard;
    logic [4:0] v;
    send_cmd(C_RUN);
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5; if_id_rt = 5'd0; #1;
    v = {enable, pc_write, if_id_write, id_ex_bubble, if_id_flush};
    n_cmp++;
    if (v !== 5'b10010) begin n_bad++; $display("FAIL load_use_rs: got %b expected 10010", v); end
    id_ex_rt = 5'd0; if_id_rs = 5'd0; #1;
    v = {enable, pc_write, if_id_write, id_ex_bubble, if_id_flush};
    n_cmp++;
    if (v !== 5'b11100) begin n_bad++; $display("FAIL load_use_r0: got %b expected 11100", v); end
    id_ex_rt = 5'd7; if_id_rs = 5'd3; if_id_rt = 5'd7; #1;
    v = {enable, pc_write, if_id_write, id_ex_bubble, if_id_flush};
    n_cmp++;
    if (v !== 5'b10010) begin n_bad++; $display("FAIL load_use_rt: got %b expected 10010", v); end
    id_ex_rt = 5'd5; if_id_rs = 5'd5; branch_taken = 1'b1; #1;
    v = {enable, pc_write, if_id_write, id_ex_bubble, if_id_flush};
    n_cmp++;
    if (v !== 5'b11101) begin n_bad++; $display("FAIL flush_branch: got %b expected 11101", v); end
    branch_taken = 1'b0; jump_sel = 1'b1; #1;
    v = {enable, pc_write, if_id_write, id_ex_bubble, if_id_flush};
    n_cmp++;
    if (v !== 5'b11101) begin n_bad++; $display("FAIL flush_jump: got %b expected 11101", v); end
    jump_sel = 1'b0;
    send_cmd(C_HALT);
    branch_taken = 1'b1; #1;
    v = {enable, pc_write, if_id_write, id_ex_bubble, if_id_flush};
    n_cmp++;
    if (v !== 5'b00100) begin n_bad++; $display("FAIL idle_no_hazard: got %b expected 00100", v); end
    clear_inputs();
  endtask

  task automatic test_halt;
    send_cmd(C_CLEAR);
    send_cmd(C_RUN);
    repeat (2) tick();
    halt_instr = 1'b1; cmd_valid = 1'b1; cmd_code = C_HALT;
    tick();
    halt_instr = 1'b0; cmd_valid = 1'b0;
    n_cmp++;
    if ({state, enable, cmd_ready, cycle_count} !== {2'b11, 1'b0, 1'b1, 32'd3}) begin
      n_bad++; $display("FAIL halt_instr_done: got state=%b en=%b rdy=%b cnt=%0d expected 11/0/1/3",
                        state, enable, cmd_ready, cycle_count);
    end
    send_cmd(C_RUN);
    repeat (3) tick();
    n_cmp++;
    if ({state, enable, cycle_count} !== {2'b11, 1'b0, 32'd3}) begin
      n_bad++; $display("FAIL done_ignores_run: got state=%b en=%b cnt=%0d expected 11/0/3", state, enable, cycle_count);
    end
    send_cmd(C_CLEAR);
    n_cmp++;
    if ({state, cycle_count} !== {2'b00, 32'd0}) begin
      n_bad++; $display("FAIL done_clear: got state=%b cnt=%0d expected 00/0", state, cycle_count);
    end
    send_cmd(C_STEP);
    halt_instr = 1'b1;
    tick();
    halt_instr = 1'b0;
    n_cmp++;
    if ({state, enable, cycle_count} !== {2'b11, 1'b0, 32'd1}) begin
      n_bad++; $display("FAIL step_halt: got state=%b en=%b cnt=%0d expected 11/0/1", state, enable, cycle_count);
    end
    send_cmd(C_CLEAR);
  endtask

  task automatic test_saturate;
    reset_s = 1'b0;
    tick();
    cmd_valid_s = 1'b1; cmd_code_s = C_RUN;
    tick();
    cmd_valid_s = 1'b0;
    repeat (20) tick();
    n_cmp++;
    if ({enable_s, cycle_count_s} !== {1'b1, 4'd15}) begin
      n_bad++; $display("FAIL saturate: got en=%b cnt=%0d expected en=1 cnt=15", enable_s, cycle_count_s);
    end
    #2 reset_s = 1'b1;
    #1;
    n_cmp++;
    if ({state_s, enable_s, pc_write_s, cycle_count_s} !== {2'b00, 1'b0, 1'b0, 4'd0}) begin
      n_bad++; $display("FAIL reset_mid_run: got state=%b en=%b pcw=%b cnt=%0d expected 00/0/0/0",
                        state_s, enable_s, pc_write_s, cycle_count_s);
    end
    #2 reset_s = 1'b0;
    tick();
    n_cmp++;
    if ({state_s, enable_s} !== 3'b000) begin
      n_bad++; $display("FAIL post_reset_idle: got state=%b en=%b expected 00/0", state_s, enable_s);
    end
  endtask

  task automatic test_random;
    int ms, nms;
    longint mcnt, mstl;
    logic e_en, lu, fl, st, acc, clr;
    logic [7:0] got, exp_v;
    ms = S_IDLE; mcnt = 0; mstl = 0;
    reset = 1'b1; #2 reset = 1'b0;
    tick();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1; #1 reset = 1'b0;
        ms = S_IDLE; mcnt = 0; mstl = 0;
      end
      cmd_valid      = ($urandom_range(0, 99) < 25);
      cmd_code       = 2'($urandom_range(0, 3));
      halt_instr     = ($urandom_range(0, 99) < 3);
      id_ex_mem_read = 1'($urandom_range(0, 1));
      id_ex_rt       = 5'($urandom_range(0, 3));
      if_id_rs       = 5'($urandom_range(0, 3));
      if_id_rt       = 5'($urandom_range(0, 3));
      branch_taken   = ($urandom_range(0, 99) < 15);
      jump_sel       = ($urandom_range(0, 99) < 10);
      #1;
      e_en  = (ms == S_RUN) || (ms == S_STEP);
      lu    = id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
      fl    = e_en && (branch_taken || jump_sel);
      st    = e_en && lu && !fl;
      exp_v = {2'(ms), e_en, e_en && !st, !st, fl, st, ms != S_STEP};
      got   = {state, enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, cmd_ready};
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", i, got, exp_v);
      end
      n_cmp++;
      if (cycle_count !== 32'(mcnt)) begin
        n_bad++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, cycle_count, mcnt);
      end
`ifdef PIPE_CTRL_STALL_CNT_EN
      n_cmp++;
      if (stall_count !== 32'(mstl)) begin
        n_bad++; $display("FAIL rand_stall_count[%0d]: got %0d expected %0d", i, stall_count, mstl);
      end
`endif
      acc = cmd_valid && ms != S_STEP;
      clr = 1'b0;
      nms = ms;
      case (ms)
        S_IDLE: begin
          if (acc && cmd_code == C_RUN)        nms = S_RUN;
          else if (acc && cmd_code == C_STEP)  nms = S_STEP;
          else if (acc && cmd_code == C_CLEAR) clr = 1'b1;
        end
        S_RUN:  nms = halt_instr ? S_DONE : ((acc && cmd_code == C_HALT) ? S_IDLE : S_RUN);
        S_STEP: nms = halt_instr ? S_DONE : S_IDLE;
        default: if (acc && cmd_code == C_CLEAR) begin nms = S_IDLE; clr = 1'b1; end
      endcase
      mcnt = clr ? 0 : ((e_en && mcnt < MAX32) ? mcnt + 1 : mcnt);
      mstl = clr ? 0 : ((st && mstl < MAX32) ? mstl + 1 : mstl);
      ms   = nms;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1; reset_s = 1'b1;
    cmd_valid_s = 1'b0; cmd_code_s = 2'b00;
    test_reset();
    test_run_count();
    test_step();
    test_hazard();
    test_halt();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of cycle_count (and stall_count).
REQ-002 SHALL have port: clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: cmd_valid  in  1  debug-UART command strobe.
REQ-005 SHALL have port: cmd_code  in  2  00 RUN, 01 STEP, 10 HALT, 11 CLEAR.
REQ-006 SHALL have port: cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
REQ-007 SHALL have port: halt_instr  in  1  HALT opcode retiring in WB.
REQ-008 SHALL have port: id_ex_mem_read  in  1  load in EX.
REQ-009 SHALL have ports: id_ex_rt, if_id_rs, if_id_rt  in  5 each  register specifiers.
REQ-010 SHALL have ports: branch_taken, jump_sel  in  1 each  control-transfer resolved.
REQ-011 SHALL have ports: enable, pc_write, if_id_write, if_id_flush, id_ex_bubble  out  1 each  pipeline latch controls.
REQ-012 SHALL have ports: cycle_count  out  CNT_W; state  out  2.

Function
REQ-013 FSM states SHALL be IDLE=00, RUN=01, STEP=10, DONE=11; state output = current state.
REQ-014 IDLE: RUN->RUN; STEP->STEP; CLEAR clears counters, stays IDLE; HALT accepted and dropped.
REQ-015 RUN: halt_instr->DONE (priority over any command); HALT cmd->IDLE; other cmds dropped.
REQ-016 STEP SHALL last exactly one cycle, then IDLE, or DONE if halt_instr is high in that cycle.
REQ-017 DONE: only CLEAR leaves (->IDLE, counters cleared); other cmds dropped.
REQ-018 cmd_ready SHALL be 1 in every state except STEP.
REQ-019 enable SHALL be 1 exactly in RUN or STEP, decoded from registered state (command at edge k -> enable high from cycle k+1).
REQ-020 load_use = id_ex_mem_read & (id_ex_rt!=0) & (id_ex_rt==if_id_rs | id_ex_rt==if_id_rt), combinational.
REQ-021 flush = enable & (branch_taken|jump_sel); if_id_flush SHALL equal flush.
REQ-022 Flush SHALL override stall: stall = enable & load_use & ~flush.
REQ-023 pc_write = enable & ~stall; if_id_write = ~stall; id_ex_bubble = stall.
REQ-024 cycle_count SHALL increment on every cycle enable=1, saturating at all-ones (no wrap).
REQ-025 CLEAR and a RUN/halt_instr event in the same cycle: state rules above apply; counter clear has priority over increment.

Reset
REQ-026 reset SHALL force state=IDLE, cycle_count=0, stall_count=0 immediately, regardless of clock.
REQ-027 During/after reset: enable=0, pc_write=0, if_id_flush=0, id_ex_bubble=0, cmd_ready=1, if_id_write=1.
REQ-028 Reset mid-RUN SHALL drop enable the same cycle; no partial step completes.

Configuration
REQ-029 Macro PIPE_CTRL_STALL_CNT_EN defined: output stall_count (CNT_W) counts cycles with stall=1, saturating, cleared by CLEAR/reset.
REQ-030 Macro undefined: stall_count port and its register SHALL be absent; all other behaviour identical.

Structure
REQ-031 Command codes, state encodings and CNT_W default SHALL live in the shared definitions header alongside PC_SIZE.
REQ-032 Load-use detection SHALL be a combinational sub-module hazard_detect; FSM and counters stay in pipe_ctrl.

Verification
REQ-033 Reset, RUN cmd -> enable=1 next cycle; 10 cycles later cycle_count=10.
REQ-034 From IDLE, STEP x3 (spaced) -> enable pulses exactly 3 single cycles, cycle_count=3, cmd_ready=0 only during each pulse.
REQ-035 RUN, id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 -> pc_write=0, if_id_write=0, id_ex_bubble=1; with id_ex_rt=0 -> no stall.
REQ-036 Same load-use plus branch_taken=1 -> if_id_flush=1, id_ex_bubble=0, pc_write=1.
REQ-037 RUN, halt_instr=1 -> DONE, enable=0; RUN cmd ignored; CLEAR -> IDLE, cycle_count=0.
REQ-038 CNT_W=4, RUN 20 cycles -> cycle_count holds 15; reset asserted mid-RUN -> state=IDLE, enable=0 before next edge.
